// File: rtl/seq_alu_unit.sv
// ---------------------------------------------------------------------------
// seq_alu_unit
//
// Execute-stage ALU that takes the 3-bit ALUControl code from the ALU decoder
// and two operands from the register file / immediate mux.
//
// Timing:
//   - Logic, add/sub and slt complete in one cycle.
//   - Shifts move one bit per cycle, so the unit needs no barrel shifter.
//   - Valid/ready handshakes on both sides let the control FSM stall while a
//     shift is in progress.
//
// Parameters:
//   WIDTH    operand/result width
//   SHAMT_W  shift-amount width (amount = src_b[SHAMT_W-1:0])
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     request valid
//   in_ready     unit can accept a request this cycle
//   alu_control  010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt,
//                100 sll, 101 srl
//   src_a        operand A
//   src_b        operand B / shift amount
//   out_valid    result valid
//   out_ready    consumer takes the result
//   result       registered result
//   zero         result == 0
//   busy         high while a multi-cycle shift is running
// ---------------------------------------------------------------------------
module seq_alu_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_control,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t               r_state;
  state_t               w_nextState;
  logic [WIDTH-1:0]     r_result;
  logic [SHAMT_W-1:0]   r_count;
  logic                 r_dirLeft;

  logic                 w_accept;
  logic                 w_inReady;
  logic                 w_isShift;
  logic [SHAMT_W-1:0]   w_shamt;
  logic                 w_startShift;
  logic                 w_lessThan;
  logic [WIDTH-1:0]     w_aluResult;

  // Shift amount comes from the low bits of operand B; upper bits are ignored,
  // so e.g. b = 0x20 is a zero-length shift that finishes in one cycle.
  assign w_shamt      = src_b[SHAMT_W-1:0];
  assign w_isShift    = (alu_control == OP_SLL) || (alu_control == OP_SRL);
  assign w_startShift = w_isShift && (w_shamt != '0);
  assign w_lessThan   = ($signed(src_a) < $signed(src_b));

  // A request can be taken in IDLE, or in DONE during the same edge the
  // current result is consumed, which gives one result per cycle for
  // single-cycle ops.
  always_comb begin
    w_inReady = 1'b0;
    case (r_state)
      IDLE:    w_inReady = 1'b1;
      DONE:    w_inReady = out_ready;
      default: w_inReady = 1'b0;
    endcase
  end

  assign w_accept = in_valid && w_inReady;

  // Single-cycle result. Zero-length shifts land here too and pass src_a.
  always_comb begin
    w_aluResult = '0;
    case (alu_control)
      OP_AND:  w_aluResult = src_a & src_b;
      OP_OR:   w_aluResult = src_a | src_b;
      OP_ADD:  w_aluResult = src_a + src_b;
      OP_XOR:  w_aluResult = src_a ^ src_b;
      OP_SUB:  w_aluResult = src_a - src_b;
      OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, w_lessThan};
      OP_SLL:  w_aluResult = src_a;
      OP_SRL:  w_aluResult = src_a;
      default: w_aluResult = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The SHIFT exit is taken on the edge where the count
  // goes from 1 to 0, so a k-bit shift spends exactly k cycles in SHIFT.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = w_startShift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_count == SHAMT_W'(1)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) begin
            w_nextState = w_startShift ? SHIFT : DONE;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath. On accept either the final result is captured, or the shift
  // operand and amount are loaded. While shifting, one bit moves per cycle
  // with zero fill (srl is logical). Otherwise the result holds, which keeps
  // it stable while DONE is back-pressured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result  <= '0;
      r_count   <= '0;
      r_dirLeft <= 1'b0;
    end else if (w_accept) begin
      if (w_startShift) begin
        r_result  <= src_a;
        r_count   <= w_shamt;
        r_dirLeft <= (alu_control == OP_SLL);
      end else begin
        r_result  <= w_aluResult;
      end
    end else if (r_state == SHIFT) begin
      r_result <= r_dirLeft ? (r_result << 1) : (r_result >> 1);
      r_count  <= r_count - SHAMT_W'(1);
    end
  end

  // Output decode.
  assign in_ready  = w_inReady;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT);
  assign result    = r_result;
  assign zero      = (r_result == '0);

endmodule

// File: tb/tb_seq_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_alu_unit
//
// Directed bench for seq_alu_unit. Each accepted request pushes its expected
// result onto a queue; a negedge monitor pops and compares whenever a result
// is handed off (out_valid & out_ready). Latency, busy duration,
// back-pressure and asynchronous reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_seq_alu_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int passCount  = 0;
  int totalCount = 0;
  logic [31:0] expQ[$];

  seq_alu_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, written independently of the RTL structure.
  function automatic logic [31:0] modelAlu(input logic [2:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (c)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return a ^ b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100:  return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Scoreboard monitor: compares every handed-off result in order.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", result, 32'hDEADBEEF);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        checkOutput("sb_result", result, e);
        checkOutput("sb_zero", {31'd0, zero}, {31'd0, (e == 32'd0)});
      end
    end
  end

  // Drive one request from IDLE (called just after a rising edge), then
  // scramble the inputs and measure the latency and busy duration.
  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] a,
                               input logic [31:0] b, input int expLat,
                               input int expBusy);
    int lat;
    int busyCycles;
    bit done;
    in_valid    = 1'b1;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    expQ.push_back(modelAlu(c, a, b));
    @(negedge clk);
    checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    src_a       = $urandom;
    src_b       = $urandom;
    alu_control = 3'($urandom_range(0, 7));
    lat = 0;
    busyCycles = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) done = 1'b1;
      else if (busy) busyCycles++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("busy_cycles", busyCycles, expBusy);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd1);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops.
    applyStimulus(3'b010, 32'h7FFFFFFF, 32'h00000001, 1, 0);
    applyStimulus(3'b110, 32'd5, 32'd5, 1, 0);
    applyStimulus(3'b111, 32'hFFFFFFFF, 32'h00000001, 1, 0);
    applyStimulus(3'b111, 32'h00000001, 32'hFFFFFFFF, 1, 0);
    applyStimulus(3'b011, 32'hF0F0F0F0, 32'hFFFF0000, 1, 0);

    // Shifts, including a zero-length shift from b = 0x20.
    applyStimulus(3'b100, 32'h00000001, 32'h0000001F, 32, 31);
    applyStimulus(3'b101, 32'h80000000, 32'h00000003, 4, 3);
    applyStimulus(3'b100, 32'h12345678, 32'h00000020, 1, 0);

    // Back-pressure: result held in DONE while a new request waits.
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    alu_control = 3'b010;
    src_a       = 32'd10;
    src_b       = 32'd20;
    expQ.push_back(32'd30);
    @(posedge clk); #1;
    alu_control = 3'b110;
    src_a       = 32'd100;
    src_b       = 32'd1;
    expQ.push_back(32'd99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_result", result, 32'd30);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back stream of four single-cycle ops.
    in_valid    = 1'b1;
    alu_control = 3'b000; src_a = 32'hF0F00000; src_b = 32'hFF00FF00;
    expQ.push_back(32'hF0000000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin alu_control = 3'b001; src_a = 32'h000000F0; src_b = 32'h0000000F; expQ.push_back(32'h000000FF); end
        1: begin alu_control = 3'b010; src_a = 32'd1; src_b = 32'd2; expQ.push_back(32'd3); end
        2: begin alu_control = 3'b110; src_a = 32'd2; src_b = 32'd3; expQ.push_back(32'hFFFFFFFF); end
        default: in_valid = 1'b0;
      endcase
      @(negedge clk);
      checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b_idle", {31'd0, out_valid}, 32'd0);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a 20-bit shift (count = 10).
    in_valid    = 1'b1;
    alu_control = 3'b100;
    src_a       = 32'h00000001;
    src_b       = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_result", result, 32'd0);
    checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd1);
    expQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(3'b010, 32'd3, 32'd4, 1, 0);
    checkOutput("final_queue_empty", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
